// File: rtl/fft_stage_feeder.sv
// fft_stage_feeder: loads one frame of N complex samples in bit-reversed
// order, then issues the N/2 operand pairs of one radix-2 DIT stage, with
// their Q2.14 twiddles, over a start/done handshake to the butterfly.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   s_valid/s_ready         sample stream handshake, s_re/s_im sample data
//   stage                   DIT stage, latched with the first sample of a frame
//   in0_*/in1_*             butterfly upper/lower operands
//   twiddle_r/twiddle_i     twiddle factor, Q2.14
//   bf_start/bf_done        butterfly handshake (start held until done)
//   bf_idx                  pair index j currently issued
//   busy                    high outside LOAD
//   frame_done              one-cycle pulse after the last pair completes
module fft_stage_feeder #(
  parameter int unsigned W     = 18,
  parameter int unsigned LOG2N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_re,
  input  logic [W-1:0]     s_im,
  input  logic [1:0]       stage,
  output logic [W-1:0]     in0_r,
  output logic [W-1:0]     in0_i,
  output logic [W-1:0]     in1_r,
  output logic [W-1:0]     in1_i,
  output logic [W-1:0]     twiddle_r,
  output logic [W-1:0]     twiddle_i,
  output logic             bf_start,
  input  logic             bf_done,
  output logic [LOG2N-1:0] bf_idx,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned N    = 1 << LOG2N;
  localparam int unsigned HALF = N / 2;

  typedef enum logic [1:0] {LOAD, SETUP, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic [LOG2N-1:0] j_q, j_d;
  logic [1:0]       stage_q, stage_d;
  logic             s_ready_d, busy_d, bf_start_d, frame_done_d;
  logic [W-1:0]     in0_r_d, in0_i_d, in1_r_d, in1_i_d, tw_r_d, tw_i_d;
  logic [LOG2N-1:0] bf_idx_d;

  logic [W-1:0]     mem_re [N];
  logic [W-1:0]     mem_im [N];

  logic             accept;
  logic [LOG2N-1:0] half_w, p, a, b;
  logic [2:0]       rom_idx;
  logic [2*W-1:0]   tw;

  assign accept = s_valid && s_ready;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    bitrev = '0;
    for (int unsigned i = 0; i < LOG2N; i++) bitrev[i] = x[LOG2N-1-i];
  endfunction

  // 16-point Q2.14 twiddle ROM, {re, im}
  function automatic logic [2*W-1:0] rom(input logic [2:0] k);
    case (k)
      3'd0:    rom = {W'(16384),  W'(0)};
      3'd1:    rom = {W'(15137),  W'(-6270)};
      3'd2:    rom = {W'(11585),  W'(-11585)};
      3'd3:    rom = {W'(6270),   W'(-15137)};
      3'd4:    rom = {W'(0),      W'(-16384)};
      3'd5:    rom = {W'(-6270),  W'(-15137)};
      3'd6:    rom = {W'(-11585), W'(-11585)};
      default: rom = {W'(-15137), W'(-6270)};
    endcase
  endfunction

  // Pair addressing; ROM index p*(N>>(s+1))*(16/N) reduces to p << (3-s)
  always_comb begin
    half_w  = LOG2N'(1) << stage_q;
    p       = j_q & (half_w - LOG2N'(1));
    a       = ((j_q >> stage_q) << (3'(stage_q) + 3'd1)) + p;
    b       = a + half_w;
    rom_idx = 3'(4'(p) << (2'd3 - stage_q));
    tw      = rom(rom_idx);
  end

  // Sample buffer, written bit-reversed
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_re[bitrev(cnt_q)] <= s_re;
      mem_im[bitrev(cnt_q)] <= s_im;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      cnt_q      <= '0;
      j_q        <= '0;
      stage_q    <= '0;
      s_ready    <= 1'b1;
      busy       <= 1'b0;
      bf_start   <= 1'b0;
      frame_done <= 1'b0;
      in0_r      <= '0;
      in0_i      <= '0;
      in1_r      <= '0;
      in1_i      <= '0;
      twiddle_r  <= '0;
      twiddle_i  <= '0;
      bf_idx     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      j_q        <= j_d;
      stage_q    <= stage_d;
      s_ready    <= s_ready_d;
      busy       <= busy_d;
      bf_start   <= bf_start_d;
      frame_done <= frame_done_d;
      in0_r      <= in0_r_d;
      in0_i      <= in0_i_d;
      in1_r      <= in1_r_d;
      in1_i      <= in1_i_d;
      twiddle_r  <= tw_r_d;
      twiddle_i  <= tw_i_d;
      bf_idx     <= bf_idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (accept && cnt_q == LOG2N'(N - 1)) state_d = SETUP;
      SETUP:   state_d = RUN;
      RUN:     if (bf_done) state_d = (j_q == LOG2N'(HALF - 1)) ? FIN : SETUP;
      default: state_d = LOAD;
    endcase
  end

  // Output and datapath next values; flags follow the state being entered
  always_comb begin
    cnt_d        = cnt_q;
    j_d          = j_q;
    stage_d      = stage_q;
    in0_r_d      = in0_r;
    in0_i_d      = in0_i;
    in1_r_d      = in1_r;
    in1_i_d      = in1_i;
    tw_r_d       = twiddle_r;
    tw_i_d       = twiddle_i;
    bf_idx_d     = bf_idx;
    s_ready_d    = (state_d == LOAD);
    busy_d       = (state_d != LOAD);
    bf_start_d   = (state_d == RUN);
    frame_done_d = (state_d == FIN);
    case (state_q)
      LOAD: begin
        if (accept) begin
          cnt_d = cnt_q + LOG2N'(1);
          if (cnt_q == '0)
            stage_d = (32'(stage) >= LOG2N) ? 2'(LOG2N - 1) : stage;
          if (cnt_q == LOG2N'(N - 1)) j_d = '0;
        end
      end
      SETUP: begin
        // Operands land together with the bf_start rising edge
        in0_r_d  = mem_re[a];
        in0_i_d  = mem_im[a];
        in1_r_d  = mem_re[b];
        in1_i_d  = mem_im[b];
        tw_r_d   = tw[2*W-1:W];
        tw_i_d   = tw[W-1:0];
        bf_idx_d = j_q;
      end
      RUN: begin
        if (bf_done && j_q != LOG2N'(HALF - 1)) j_d = j_q + LOG2N'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fft_stage_feeder.sv
// Self-checking bench for fft_stage_feeder (W=18, N=8): directed frames with
// random data, checked against an array model of bit-reversed storage and
// DIT pair/twiddle selection.
module tb_fft_stage_feeder;
  localparam int W = 18;
  localparam int LOG2N = 3;
  localparam int N = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [W-1:0]     s_re = '0;
  logic [W-1:0]     s_im = '0;
  logic [1:0]       stage = '0;
  logic [W-1:0]     in0_r, in0_i, in1_r, in1_i, twiddle_r, twiddle_i;
  logic             bf_start;
  logic             bf_done = 1'b0;
  logic [LOG2N-1:0] bf_idx;
  logic             busy;
  logic             frame_done;

  fft_stage_feeder #(.W(W), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_re(s_re), .s_im(s_im), .stage(stage),
    .in0_r(in0_r), .in0_i(in0_i), .in1_r(in1_r), .in1_i(in1_i),
    .twiddle_r(twiddle_r), .twiddle_i(twiddle_i),
    .bf_start(bf_start), .bf_done(bf_done), .bf_idx(bf_idx),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_asrt = 0;
  int n_fail = 0;
  int rom_re [8] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
  int rom_im [8] = '{0, -6270, -11585, -15137, -16384, -15137, -11585, -6270};
  int samp_re [N];
  int samp_im [N];
  int mref_re [N];
  int mref_im [N];

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle, optionally pushing junk samples the DUT must ignore
  task automatic step(input bit junk);
    if (junk) begin
      s_valid = 1'b1;
      s_re = W'($urandom);
      s_im = W'($urandom);
    end
    tick();
  endtask

  function automatic int rev(input int n);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) r = r * 2 + ((n >> i) & 1);
    return r;
  endfunction

  task automatic set_lin(input int base, input int stepv);
    for (int n = 0; n < N; n++) begin
      samp_re[n] = base + n * stepv;
      samp_im[n] = 0;
    end
  endtask

  task automatic set_rand();
    logic [W-1:0] r;
    for (int n = 0; n < N; n++) begin
      r = W'($urandom);
      samp_re[n] = int'($signed(r));
      r = W'($urandom);
      samp_im[n] = int'($signed(r));
    end
  endtask

  // Push one frame; stage is driven with the first sample only matters there
  task automatic load_frame(input int st, input bit gaps);
    for (int n = 0; n < N; n++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          s_valid = 1'b0;
          tick();
        end
      end
      chk("s_ready_load", s_ready, 1);
      s_valid = 1'b1;
      s_re = W'(samp_re[n]);
      s_im = W'(samp_im[n]);
      stage = (n == 0) ? 2'(st) : 2'($urandom_range(0, 3));
      tick();
    end
    s_valid = 1'b0;
    chk("s_ready_setup", s_ready, 0);
    chk("busy_setup", busy, 1);
    for (int n = 0; n < N; n++) begin
      mref_re[rev(n)] = samp_re[n];
      mref_im[rev(n)] = samp_im[n];
    end
  endtask

  // Issue and complete all pairs; returns early at the start of pair stop_at
  task automatic run_frame(input int st, input int delay, input bit junk,
                           input bit stray, input int stop_at);
    int s_eff, p, a, b, ri, wcnt;
    s_eff = (st >= LOG2N) ? LOG2N - 1 : st;
    for (int j = 0; j < N / 2; j++) begin
      wcnt = 0;
      while (bf_start !== 1'b1 && wcnt < 20) begin
        step(junk);
        wcnt++;
      end
      chk("start_wait", bf_start, 1);
      if (j == stop_at) return;
      p  = j & ((1 << s_eff) - 1);
      a  = ((j >> s_eff) << (s_eff + 1)) + p;
      b  = a + (1 << s_eff);
      ri = p * (N >> (s_eff + 1)) * (16 / N);
      chk("bf_idx", bf_idx, j);
      chk("in0_r", $signed(in0_r), mref_re[a]);
      chk("in0_i", $signed(in0_i), mref_im[a]);
      chk("in1_r", $signed(in1_r), mref_re[b]);
      chk("in1_i", $signed(in1_i), mref_im[b]);
      chk("tw_r", $signed(twiddle_r), rom_re[ri]);
      chk("tw_i", $signed(twiddle_i), rom_im[ri]);
      chk("busy_run", busy, 1);
      for (int k = 1; k < delay; k++) begin
        step(junk);
        chk("start_hold", bf_start, 1);
        chk("in0_hold", $signed(in0_r), mref_re[a]);
        chk("in1_hold", $signed(in1_r), mref_re[b]);
        if (junk) chk("s_ready_run", s_ready, 0);
      end
      bf_done = 1'b1;
      step(junk);
      bf_done = 1'b0;
      chk("start_low", bf_start, 0);
      if (j < N / 2 - 1) begin
        chk("frame_done_early", frame_done, 0);
        if (stray) bf_done = 1'b1;
        step(junk);
        bf_done = 1'b0;
        chk("restart", bf_start, 1);
      end else begin
        chk("frame_done", frame_done, 1);
        s_valid = 1'b0;
        if (stray) bf_done = 1'b1;
        tick();
        bf_done = 1'b0;
        chk("frame_done_pulse", frame_done, 0);
        chk("s_ready_idle", s_ready, 1);
        chk("busy_idle", busy, 0);
        tick();
        chk("start_idle", bf_start, 0);
      end
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_s_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_bf_start", bf_start, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_in0_r", in0_r, 0);
    chk("rst_in1_i", in1_i, 0);
    chk("rst_twiddle_r", twiddle_r, 0);
    chk("rst_bf_idx", bf_idx, 0);
  endtask

  initial begin
    // Asynchronous reset mid-cycle
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    tick();
    #2 rst_n = 1'b1;
    tick();

    // Stage 0 with linear samples, done 7 cycles after start
    set_lin(0, 100);
    load_frame(0, 1'b0);
    run_frame(0, 7, 1'b0, 1'b0, -1);

    // Stage 2, same samples
    load_frame(2, 1'b0);
    run_frame(2, 7, 1'b0, 1'b0, -1);

    // Random data, stage 1, long stall and stray dones in SETUP/FIN
    set_rand();
    load_frame(1, 1'b0);
    run_frame(1, 20, 1'b0, 1'b1, -1);

    // Gapped load, stage 3 clamped, junk samples while busy
    set_rand();
    load_frame(3, 1'b1);
    run_frame(3, 3, 1'b1, 1'b0, -1);

    // Reset during pair 2, then reload
    set_rand();
    load_frame(1, 1'b1);
    run_frame(1, 2, 1'b0, 1'b0, 2);
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    tick();
    #2 rst_n = 1'b1;
    tick();
    set_lin(1000, 1);
    load_frame(0, 1'b0);
    run_frame(0, 4, 1'b0, 1'b0, -1);

    // Random stages with random data
    for (int f = 0; f < 3; f++) begin
      int st;
      st = $urandom_range(0, 3);
      set_rand();
      load_frame(st, 1'b1);
      run_frame(st, $urandom_range(1, 9), 1'b1, 1'b1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
